// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Receives an instruction image as a byte stream and writes it
//            into an instruction memory. The stream is one length byte N
//            (1..DEPTH) followed by N little-endian 3-byte words.
//            Malformed streams end the load with err set.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            start                 - one-cycle pulse that begins a new load
//            byte_valid/byte_data  - serial byte input
//            byte_ready            - byte accepted this cycle
//            wr_en/wr_addr/wr_data - instruction memory write port
//            busy/done/err         - load status (done/err are sticky)
//            word_count            - words written in the current load
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_B0    = 3'd2,
    S_B1    = 3'd3,
    S_B2    = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] C_DEPTH_B = 8'(DEPTH);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0]  word_count_q, word_count_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]         b0_q, b0_d;
  logic [7:0]         b1_q, b1_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               in_byte_state;
  logic               xfer;
  logic [ADDR_W-1:0]  wc_inc;

  // byte_ready is the only combinational output; start has priority so a
  // byte offered alongside start is never consumed.
  assign in_byte_state = (state_q == S_LEN) || (state_q == S_B0) ||
                         (state_q == S_B1)  || (state_q == S_B2);
  assign byte_ready    = in_byte_state && !start;
  assign xfer          = byte_ready && byte_valid;
  assign wc_inc        = word_count_q + ADDR_W'(1);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    wr_en_d      = 1'b0;

    if (start) begin
      state_d      = S_LEN;
      word_count_d = '0;
      wr_addr_d    = '0;
    end else begin
      case (state_q)
        S_LEN: if (xfer) begin
          len_d = ADDR_W'(byte_data);
          if ((byte_data == 8'd0) || (byte_data > C_DEPTH_B)) state_d = S_ERR;
          else                                               state_d = S_B0;
        end
        S_B0: if (xfer) begin
          b0_d    = byte_data;
          state_d = S_B1;
        end
        S_B1: if (xfer) begin
          b1_d    = byte_data;
          state_d = S_B2;
        end
        S_B2: if (xfer) begin
          // Only 3 bits of the top byte belong to the word; anything else
          // in that byte means the stream is malformed.
          if (byte_data[7:3] != 5'd0) begin
            state_d = S_ERR;
          end else begin
            wr_data_d = INSTR_W'({byte_data[2:0], b1_q, b0_q});
            wr_addr_d = word_count_q;
            wr_en_d   = 1'b1;
            state_d   = S_WRITE;
          end
        end
        S_WRITE: begin
          word_count_d = wc_inc;
          state_d      = (wc_inc == len_q) ? S_DONE : S_B0;
        end
        default: state_d = state_q;  // IDLE, DONE, ERR hold until start
      endcase
    end

    // Status flags are registered images of the next state.
    busy_d = (state_d == S_LEN) || (state_d == S_B0) || (state_d == S_B1) ||
             (state_d == S_B2)  || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_loader
// Purpose  : Self-checking bench for inst_mem_loader. A table of per-cycle
//            vectors covers the two-word load; directed sequences cover the
//            format errors, flow control, restart and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [18:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  word_count;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;

  inst_mem_loader #(.INSTR_W(19), .ADDR_W(8), .DEPTH(26)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Count write strobes mid-cycle.
  always @(negedge clk) if (wr_en) wr_cnt++;

  typedef struct {
    logic        st;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;   // byte_ready before the edge
    logic        we;    // registered outputs after the edge
    logic [7:0]  wa;
    logic [18:0] wd;
    logic        bsy;
    logic        dn;
    logic        er;
    logic [7:0]  wc;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic bv, input logic [7:0] bd);
    start = st; byte_valid = bv; byte_data = bd;
    @(posedge clk); #1;
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic e,
                            input logic [7:0] wc);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".err"},  {31'd0, err},  {31'd0, e});
    chk({tag, ".wc"},   {24'd0, word_count}, {24'd0, wc});
  endtask

  int w0;

  initial begin
    // Two-word load: N=2, words 0x00160 and 0x00261.
    tbl[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 19'h00000, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'd0, 19'h00000, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h60, 1'b1, 1'b0, 8'd0, 19'h00000, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'd0, 19'h00000, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'd0, 19'h00160, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 8'd0, 19'h00160, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{1'b0, 1'b1, 8'h61, 1'b1, 1'b0, 8'd0, 19'h00160, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'd0, 19'h00160, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'd1, 19'h00261, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 19'h00261, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[10] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'd1, 19'h00261, 1'b0, 1'b1, 1'b0, 8'd2};

    // Reset, with a start pulse held during reset that must be ignored.
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h05;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.ready", {31'd0, byte_ready}, 32'd0);
    chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst.addr",  {24'd0, wr_addr}, 32'd0);
    chk("rst.data",  {13'd0, wr_data}, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 8'd0);
    start = 1'b0; byte_valid = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h02);
    chk_status("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // Table-driven two-word load.
    w0 = wr_cnt;
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; byte_valid = tbl[i].bv; byte_data = tbl[i].bd;
      #1;
      chk($sformatf("v%0d.ready", i), {31'd0, byte_ready}, {31'd0, tbl[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d.wr_en", i), {31'd0, wr_en}, {31'd0, tbl[i].we});
      chk($sformatf("v%0d.addr", i),  {24'd0, wr_addr}, {24'd0, tbl[i].wa});
      chk($sformatf("v%0d.data", i),  {13'd0, wr_data}, {13'd0, tbl[i].wd});
      chk_status($sformatf("v%0d", i), tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].wc);
    end
    chk("two_word.writes", wr_cnt - w0, 32'd2);

    // Length 0 and length 27 are format errors; length 26 is accepted.
    w0 = wr_cnt;
    step(1'b1, 1'b0, 8'h00);
    chk_status("start_clears", 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'h00);
    chk_status("len0", 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'h01);
    chk_status("len0_sticky", 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h1B);
    chk_status("len27", 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h1A);
    chk_status("len26", 1'b1, 1'b0, 1'b0, 8'd0);
    chk("len_err.writes", wr_cnt - w0, 32'd0);

    // Top byte with bits [7:3] set aborts; 07 is the largest legal top byte.
    w0 = wr_cnt;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h08);
    chk_status("top08", 1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b0, 8'h00);
    chk("top08.writes", wr_cnt - w0, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h07);
    chk("top07.wr_en", {31'd0, wr_en}, 32'd1);
    chk("top07.addr",  {24'd0, wr_addr}, 32'd0);
    chk("top07.data",  {13'd0, wr_data}, 32'h7FFFF);
    step(1'b0, 1'b0, 8'h00);
    chk_status("top07", 1'b0, 1'b1, 1'b0, 8'd1);

    // byte_valid toggling: each byte is taken exactly once.
    w0 = wr_cnt;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'hEE);
    step(1'b0, 1'b1, 8'h34);
    step(1'b0, 1'b0, 8'hEE);
    step(1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b0, 8'hEE);
    step(1'b0, 1'b1, 8'h05);
    chk("toggle.wr_en", {31'd0, wr_en}, 32'd1);
    chk("toggle.data",  {13'd0, wr_data}, 32'h51234);
    step(1'b0, 1'b0, 8'hEE);
    chk_status("toggle", 1'b0, 1'b1, 1'b0, 8'd1);
    chk("toggle.writes", wr_cnt - w0, 32'd1);

    // Restart during word 3 of a 4-word load.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h04);
    for (int w = 1; w <= 2; w++) begin
      step(1'b0, 1'b1, 8'(w));
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b0, 8'h00);
    end
    chk("restart.pre_wc", {24'd0, word_count}, 32'd2);
    chk("restart.pre_addr", {24'd0, wr_addr}, 32'd1);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h04);
    step(1'b1, 1'b1, 8'h05);
    chk_status("restart", 1'b1, 1'b0, 1'b0, 8'd0);
    chk("restart.addr", {24'd0, wr_addr}, 32'd0);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h0A);
    step(1'b0, 1'b1, 8'h0B);
    step(1'b0, 1'b1, 8'h01);
    chk("restart.wr_en", {31'd0, wr_en}, 32'd1);
    chk("restart.waddr", {24'd0, wr_addr}, 32'd0);
    chk("restart.data",  {13'd0, wr_data}, 32'h10B0A);

    // Asynchronous reset in B1.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ready", {31'd0, byte_ready}, 32'd0);
    chk_status("arst", 1'b0, 1'b0, 1'b0, 8'd0);
    w0 = wr_cnt;
    step(1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h22);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'h00);
    chk("arst.ready_idle", {31'd0, byte_ready}, 32'd0);
    chk_status("arst_rel", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("arst.writes", wr_cnt - w0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
